dot_cmd_sequencer: RTL and testbench

- Drives the 16-bit switch command bus consumed by dot_product, so vectors can be loaded and computed from logic rather than by hand.
- Accepts element pairs (a_i, b_i) on a valid/ready stream.
- Emits timed write-A, write-B and compute command pulses in dot_product's switch encoding.
- Sits between a host or ROM source and dot_product's sw input.

---
 rtl/dot_pkg.sv | 49 ++++
 rtl/dwell_counter.sv | 26 ++
 rtl/dot_cmd_sequencer.sv | 134 +++++++++++++
 tb/tb_dot_cmd_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot_product switch command bus and its sequencer.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package dot_pkg;

    // Command codes carried in sw[15:12]
    localparam logic [3:0] CMD_IDLE    = 4'b0000;
    localparam logic [3:0] CMD_WR_A    = 4'b0001;
    localparam logic [3:0] CMD_WR_B    = 4'b0010;
    localparam logic [3:0] CMD_COMPUTE = 4'b1100;

    // Field layout of the 16-bit switch bus, MSB first
    typedef struct packed {
        logic [3:0] cmd;
        logic [1:0] rsvd;
        logic [1:0] idx;
        logic [7:0] dat;
    } sw_t;

    // Sequencer FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_WR_A    = 3'd2;
    localparam logic [2:0] ST_GAP_A   = 3'd3;
    localparam logic [2:0] ST_WR_B    = 3'd4;
    localparam logic [2:0] ST_GAP_B   = 3'd5;
    localparam logic [2:0] ST_COMPUTE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // Assemble a bus word; the reserved bits are always zero
    function automatic logic [15:0] sw_pack(input logic [3:0] cmd,
                                            input logic [1:0] idx,
                                            input logic [7:0] dat);
        sw_t f;
        f.cmd  = cmd;
        f.rsvd = 2'b00;
        f.idx  = idx;
        f.dat  = dat;
        return f;
    endfunction

    // Counter reload value for an N-cycle dwell; N=0 is clamped to one cycle
    function automatic logic [15:0] dwell_load(input int unsigned n);
        if (n == 0)
            return 16'd0;
        return 16'(n - 1);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Down-counter timing how long the sequencer stays in a state.
// Latency: load takes effect at the next edge; expire is combinational from the count.
// Backpressure: none; counts every cycle until it reaches zero and then holds.
module dwell_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        expire
);

    logic [15:0] cnt;

    // Reload on state entry, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 16'd1;
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/dot_cmd_sequencer.sv
// Streams (a,b) element pairs into timed WR_A/WR_B/COMPUTE pulses on dot_product's switch bus.
// Latency: the accepting edge already shows WR_A on sw; every output is a register.
// Backpressure: in_ready only in WAIT_ELEM; abort port and behaviour exist only with SEQ_ABORT_EN.
module dot_cmd_sequencer
    import dot_pkg::*;
#(
    parameter int unsigned VEC_LEN     = 4,    // 1..4, index field is two bits
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned GAP_CYC     = 10,
    parameter int unsigned COMPUTE_CYC = 100
) (
`ifdef SEQ_ABORT_EN
    input  logic        abort,
`endif
    input  logic        clk,
    input  logic        btnc,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [15:0] sw,
    output logic        busy,
    output logic        done,
    output logic [1:0]  elem_idx
);

    localparam logic [15:0] PULSE_LD   = dwell_load(PULSE_CYC);
    localparam logic [15:0] GAP_LD     = dwell_load(GAP_CYC);
    localparam logic [15:0] COMPUTE_LD = dwell_load(COMPUTE_CYC);
    localparam logic [1:0]  LAST_IDX   = 2'(VEC_LEN - 1);

    logic [2:0]  state, state_n;
    logic [1:0]  idx_n;
    logic [7:0]  a_q, b_q, a_n, b_n;
    logic [15:0] sw_n, dwell_val;
    logic        busy_n, done_n, rdy_n;
    logic        dwell_exp, abort_hit;

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Next state, element index and latched operands
    always_comb begin
        state_n = state;
        idx_n   = elem_idx;
        a_n     = a_q;
        b_n     = b_q;
        case (state)
            ST_IDLE:    if (start) begin
                            state_n = ST_WAIT;
                            idx_n   = 2'd0;
                        end
            ST_WAIT:    if (in_valid && in_ready) begin
                            a_n     = in_a;
                            b_n     = in_b;
                            state_n = ST_WR_A;
                        end
            ST_WR_A:    if (dwell_exp) state_n = ST_GAP_A;
            ST_GAP_A:   if (dwell_exp) state_n = ST_WR_B;
            ST_WR_B:    if (dwell_exp) state_n = ST_GAP_B;
            ST_GAP_B:   if (dwell_exp) begin
                            if (elem_idx == LAST_IDX) begin
                                state_n = ST_COMPUTE;
                            end else begin
                                state_n = ST_WAIT;
                                idx_n   = elem_idx + 2'd1;
                            end
                        end
            ST_COMPUTE: if (dwell_exp) begin
                            state_n = ST_DONE;
                            idx_n   = 2'd0;
                        end
            default:    state_n = ST_IDLE;   // ST_DONE lasts exactly one cycle
        endcase
        if (abort_hit) begin
            state_n = ST_IDLE;
            idx_n   = 2'd0;
        end
    end

    // Output values for the state being entered, so they register on the same edge
    always_comb begin
        sw_n      = 16'h0000;
        dwell_val = 16'd0;
        case (state_n)
            ST_WAIT:    sw_n = sw_pack(CMD_IDLE, idx_n, sw[7:0]);
            ST_WR_A:    begin sw_n = sw_pack(CMD_WR_A, idx_n, a_n); dwell_val = PULSE_LD; end
            ST_GAP_A:   begin sw_n = sw_pack(CMD_IDLE, idx_n, a_n); dwell_val = GAP_LD;   end
            ST_WR_B:    begin sw_n = sw_pack(CMD_WR_B, idx_n, b_n); dwell_val = PULSE_LD; end
            ST_GAP_B:   begin sw_n = sw_pack(CMD_IDLE, idx_n, b_n); dwell_val = GAP_LD;   end
            ST_COMPUTE: begin sw_n = sw_pack(CMD_COMPUTE, 2'd0, 8'h00); dwell_val = COMPUTE_LD; end
            default:    sw_n = 16'h0000;
        endcase
        busy_n = (state_n != ST_IDLE) && (state_n != ST_DONE);
        done_n = (state_n == ST_DONE);
        rdy_n  = (state_n == ST_WAIT);
    end

    dwell_counter u_dwell (
        .clk      (clk),
        .rst      (btnc),
        .load     (state_n != state),
        .load_val (dwell_val),
        .expire   (dwell_exp)
    );

    // State and registered outputs; reset aborts with no pulse completion
    always_ff @(posedge clk or posedge btnc) begin
        if (btnc) begin
            state    <= ST_IDLE;
            elem_idx <= 2'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            sw       <= 16'h0000;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            elem_idx <= idx_n;
            a_q      <= a_n;
            b_q      <= b_n;
            sw       <= sw_n;
            busy     <= busy_n;
            done     <= done_n;
            in_ready <= rdy_n;
        end
    end

endmodule

// File: tb/tb_dot_cmd_sequencer.sv
// Self-checking bench for dot_cmd_sequencer: table of vector loads plus reset/abort sequences.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: exercised with long in_valid-low stretches and ignored start/in_valid noise.
module tb_dot_cmd_sequencer;

    localparam int PULSE = 2;
    localparam int GAP   = 10;
    localparam int COMP  = 100;
    localparam int ELEM  = 2 * (PULSE + GAP);

    logic        clk = 1'b0;
    logic        btnc = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        in_ready, busy, done;
    logic [15:0] sw;
    logic [1:0]  elem_idx;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              low;
        bit              noise;
        logic [31:0]     exp_dot;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    dot_cmd_sequencer #(
        .VEC_LEN(4), .PULSE_CYC(PULSE), .GAP_CYC(GAP), .COMPUTE_CYC(COMP)
    ) dut (
`ifdef SEQ_ABORT_EN
        .abort    (abort),
`endif
        .clk      (clk),
        .btnc     (btnc),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .sw       (sw),
        .busy     (busy),
        .done     (done),
        .elem_idx (elem_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected bus word k cycles after element i was accepted
    function automatic logic [15:0] model_sw(input int i, input int k,
                                             input logic [7:0] a, input logic [7:0] b);
        logic [3:0] cmd;
        logic [7:0] d;
        if (k < PULSE)                  begin cmd = 4'h1; d = a; end
        else if (k < PULSE + GAP)       begin cmd = 4'h0; d = a; end
        else if (k < 2 * PULSE + GAP)   begin cmd = 4'h2; d = b; end
        else                            begin cmd = 4'h0; d = b; end
        return {cmd, 2'b00, 2'(i), d};
    endfunction

    task automatic run_vec(input logic [3:0][7:0] va, input logic [3:0][7:0] vb,
                           input int low, input bit noise, input logic [31:0] exp_dot,
                           input int abort_cyc);
        int              errs;
        logic [15:0]     f_act, f_exp;
        logic [3:0][7:0] da, db;
        logic [31:0]     dot;
        int              seen_done;
        errs = 0; f_act = '0; f_exp = '0; da = '0; db = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_idx", 32'(elem_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            // waiting for an element: idle command, ready, index i
            for (int c = 0; c <= low; c++) begin
                if (in_ready !== 1'b1 || sw[15:8] !== {6'b0, 2'(i)} || elem_idx !== 2'(i)) begin
                    if (errs == 0) begin f_act = sw; f_exp = {6'b0, 2'(i), 8'h00}; end
                    errs++;
                end
                start    = noise ? 1'($urandom_range(1)) : 1'b0;
                in_valid = (c == low);
                in_a     = va[i];
                in_b     = vb[i];
                @(negedge clk);
            end
            check("rdy_drop", 32'(in_ready), 32'd0);
            for (int k = 0; k < ELEM; k++) begin
                if (sw !== model_sw(i, k, va[i], vb[i]) || elem_idx !== 2'(i) || busy !== 1'b1) begin
                    if (errs == 0) begin f_act = sw; f_exp = model_sw(i, k, va[i], vb[i]); end
                    errs++;
                end
                if (sw[15:12] == 4'h1) da[sw[9:8]] = sw[7:0];
                if (sw[15:12] == 4'h2) db[sw[9:8]] = sw[7:0];
                in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
                start    = noise ? 1'($urandom_range(1)) : 1'b0;
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                @(negedge clk);
            end
        end
        for (int k = 0; k < COMP; k++) begin
            if (sw !== 16'hC000 || done !== 1'b0 || busy !== 1'b1) begin
                if (errs == 0) begin f_act = sw; f_exp = 16'hC000; end
                errs++;
            end
`ifdef SEQ_ABORT_EN
            if (k == abort_cyc) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; in_valid = 1'b0; start = 1'b0;
                check("abort_sw", 32'(sw), 32'h0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_idx", 32'(elem_idx), 32'd0);
                seen_done = 0;
                for (int w = 0; w < COMP + 20; w++) begin
                    if (done === 1'b1) seen_done++;
                    @(negedge clk);
                end
                check("abort_no_done", 32'(seen_done), 32'd0);
                return;
            end
`endif
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_sw", 32'(sw), 32'h0);
        check("done_idx", 32'(elem_idx), 32'd0);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("idle_rdy", 32'(in_ready), 32'd0);
        if (errs != 0)
            $display("first trace difference: sw=%h model=%h", f_act, f_exp);
        check("sw_trace_errs", 32'(errs), 32'd0);
        dot = '0;
        for (int i = 0; i < 4; i++) dot += 32'(da[i]) * 32'(db[i]);
        check("dot_result", dot, exp_dot);
    endtask

    initial begin
        // vector table: fixed patterns, then randomized rows with arithmetic expectations
        tbl[0].a = {8'd2, 8'd2, 8'd2, 8'd2}; tbl[0].b = {8'd2, 8'd2, 8'd2, 8'd2};
        tbl[0].low = 0; tbl[0].noise = 1'b0; tbl[0].exp_dot = 32'd16;
        tbl[1].a = {4{8'hFF}}; tbl[1].b = {4{8'hFF}};
        tbl[1].low = 0; tbl[1].noise = 1'b0; tbl[1].exp_dot = 32'h3F804;
        tbl[2].a = {8'd4, 8'd3, 8'd2, 8'd1}; tbl[2].b = {8'd8, 8'd7, 8'd6, 8'd5};
        tbl[2].low = 50; tbl[2].noise = 1'b0; tbl[2].exp_dot = 32'd70;
        for (int r = 3; r < 5; r++) begin
            tbl[r].exp_dot = '0;
            for (int i = 0; i < 4; i++) begin
                tbl[r].a[i] = 8'($urandom);
                tbl[r].b[i] = 8'($urandom);
                tbl[r].exp_dot += 32'(tbl[r].a[i]) * 32'(tbl[r].b[i]);
            end
            tbl[r].low = int'($urandom_range(8));
            tbl[r].noise = 1'b1;
        end

        // power-on reset values
        @(negedge clk); @(negedge clk);
        check("rst_sw", 32'(sw), 32'h0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(elem_idx), 32'd0);
        btnc = 1'b0;

        // reset asserted mid-WR_A clears outputs immediately
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h33;
        @(negedge clk); in_valid = 1'b0;
        check("pre_rst_wra", 32'(sw), 32'h105A);
        #1 btnc = 1'b1;
        #1;
        check("midrst_sw", 32'(sw), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdy", 32'(in_ready), 32'd0);
        @(negedge clk); btnc = 1'b0;
        repeat (5) @(negedge clk);
        check("postrst_sw", 32'(sw), 32'h0);
        check("postrst_busy", 32'(busy), 32'd0);

        // start together with reset: reset wins
        btnc = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0; btnc = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_rdy", 32'(in_ready), 32'd0);

        for (int r = 0; r < 5; r++)
            run_vec(tbl[r].a, tbl[r].b, tbl[r].low, tbl[r].noise, tbl[r].exp_dot, -1);

`ifdef SEQ_ABORT_EN
        run_vec(tbl[0].a, tbl[0].b, 0, 1'b0, tbl[0].exp_dot, 50);
        run_vec(tbl[0].a, tbl[0].b, 0, 1'b0, tbl[0].exp_dot, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
